// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic MIPS instruction requests into 32-bit words
// and writes them to consecutive instruction-memory addresses starting at 0.
// Latency: handshake at edge N, ENC during the next cycle, mem_we high during the
//          cycle that ends at edge N+2, where the memory captures the word.
// Backpressure: req_ready is high only in IDLE, so one request is taken every 3 cycles.
//               It stays low once the memory is full.
//
// Ports:
//   clk, rst               clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_op/rs/rt/rd/imm    symbolic instruction
//                          op: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 ori, 7 andi,
//                              8 lw, 9 sw, 10 slti, 11 beq, 12 bne, 13 bgtz, 14 j
//   mem_we/addr/wdata      instruction-memory write port
//   instr_count            number of words written since reset
//   full                   the last address has been written; terminal until reset
//   err                    sticky; set when an invalid op is received
//
// Configuration macro:
//   INSTR_ENC_JUMP_EN      when defined, op 14 encodes j.
//                          When undefined, op 14 is invalid and no J-type logic exists.

module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [25:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   instr_count,
    output logic              full,
    output logic              err
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENC   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    // Symbolic op codes on req_op
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_ANDI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_SLTI = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_BGTZ = 4'd13;
`ifdef INSTR_ENC_JUMP_EN
    localparam logic [3:0] OP_J    = 4'd14;
`endif

    // MIPS opcode and funct fields, matching the control-unit decode
    localparam logic [5:0] MIPS_RTYPE = 6'b000000;
    localparam logic [5:0] MIPS_ADDI  = 6'b001000;
    localparam logic [5:0] MIPS_ORI   = 6'b001101;
    localparam logic [5:0] MIPS_ANDI  = 6'b001100;
    localparam logic [5:0] MIPS_LW    = 6'b100011;
    localparam logic [5:0] MIPS_SW    = 6'b101011;
    localparam logic [5:0] MIPS_SLTI  = 6'b001010;
    localparam logic [5:0] MIPS_BEQ   = 6'b000100;
    localparam logic [5:0] MIPS_BNE   = 6'b000101;
    localparam logic [5:0] MIPS_BGTZ  = 6'b000111;
`ifdef INSTR_ENC_JUMP_EN
    localparam logic [5:0] MIPS_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // Only J-type needs the upper ten immediate bits.
    // Without it, the captured immediate is narrowed to 16 bits.
`ifdef INSTR_ENC_JUMP_EN
    localparam int IMM_W = 26;
`else
    localparam int IMM_W = 16;
    logic unused_imm_hi;
    assign unused_imm_hi = ^req_imm[25:16];
`endif

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [IMM_W-1:0]  imm_q;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_ok;

    assign req_ready   = (state_q == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign mem_we      = (state_q == ST_WRITE);
    assign full        = (state_q == ST_FULL);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign instr_count = count_q;
    assign err         = err_q;

    // Request capture: the fields are held from the handshake until the next
    // handshake, so the inputs are free to change during ENC and WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            rs_q  <= req_rs;
            rt_q  <= req_rt;
            rd_q  <= req_rd;
            imm_q <= req_imm[IMM_W-1:0];
        end
    end

    // Encoder: works on the captured fields and is only consumed in ENC
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (op_q)
            OP_ADD:  enc_word = {MIPS_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_ADD};
            OP_SUB:  enc_word = {MIPS_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_SUB};
            OP_AND:  enc_word = {MIPS_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_AND};
            OP_OR:   enc_word = {MIPS_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_OR};
            OP_SLT:  enc_word = {MIPS_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_SLT};
            OP_ADDI: enc_word = {MIPS_ADDI, rs_q, rt_q, imm_q[15:0]};
            OP_ORI:  enc_word = {MIPS_ORI,  rs_q, rt_q, imm_q[15:0]};
            OP_ANDI: enc_word = {MIPS_ANDI, rs_q, rt_q, imm_q[15:0]};
            OP_LW:   enc_word = {MIPS_LW,   rs_q, rt_q, imm_q[15:0]};
            OP_SW:   enc_word = {MIPS_SW,   rs_q, rt_q, imm_q[15:0]};
            OP_SLTI: enc_word = {MIPS_SLTI, rs_q, rt_q, imm_q[15:0]};
            OP_BEQ:  enc_word = {MIPS_BEQ,  rs_q, rt_q, imm_q[15:0]};
            OP_BNE:  enc_word = {MIPS_BNE,  rs_q, rt_q, imm_q[15:0]};
            // bgtz compares rs against zero; the rt slot must read as $0
            OP_BGTZ: enc_word = {MIPS_BGTZ, rs_q, 5'd0, imm_q[15:0]};
`ifdef INSTR_ENC_JUMP_EN
            OP_J:    enc_word = {MIPS_J, imm_q[25:0]};
`endif
            default: enc_ok   = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                if (enc_ok) begin
                    wdata_d = enc_word;
                    state_d = ST_WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ADDR_W+1)'(1);
                // The address is held at the last slot rather than wrapping.
                // FULL then blocks any further writes.
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_FULL;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wdata_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule
